// File: rtl/display_scan_controller_pkg.sv
// Shared types and seven-segment constants for the display scan controller.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order.
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StConvert,
        StUpdate
    } state_e;

    typedef enum logic [1:0] {
        DigUnits,
        DigTens,
        DigHundreds,
        DigSign
    } digit_e;

    localparam logic [6:0] Seg0     = 7'h3F;
    localparam logic [6:0] Seg1     = 7'h06;
    localparam logic [6:0] Seg2     = 7'h5B;
    localparam logic [6:0] Seg3     = 7'h4F;
    localparam logic [6:0] Seg4     = 7'h66;
    localparam logic [6:0] Seg5     = 7'h6D;
    localparam logic [6:0] Seg6     = 7'h7D;
    localparam logic [6:0] Seg7     = 7'h07;
    localparam logic [6:0] Seg8     = 7'h7F;
    localparam logic [6:0] Seg9     = 7'h6F;
    localparam logic [6:0] SegBlank = 7'h00;
    localparam logic [6:0] SegMinus = 7'h40;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = Seg0;
            4'd1:    s = Seg1;
            4'd2:    s = Seg2;
            4'd3:    s = Seg3;
            4'd4:    s = Seg4;
            4'd5:    s = Seg5;
            4'd6:    s = Seg6;
            4'd7:    s = Seg7;
            4'd8:    s = Seg8;
            4'd9:    s = Seg9;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-add-3 (double dabble) converter: start loads the binary value
// and clears the BCD digits, each shift_en consumes one bit MSB first.
module bin_to_bcd_serial #(
    parameter int unsigned IN_WIDTH = 9,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  shift_en,
    input  logic [IN_WIDTH-1:0]   value,
    output logic [DIGITS*4-1:0]   bcd
);

    logic [IN_WIDTH-1:0] shreg_q;
    logic [DIGITS*4-1:0] bcd_q;
    logic [DIGITS*4-1:0] adj;

    // Any digit >= 5 gets +3 so the following shift carries correctly into the next digit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            bcd_q   <= '0;
        end else if (start) begin
            shreg_q <= value;
            bcd_q   <= '0;
        end else if (shift_en) begin
            bcd_q   <= {adj[DIGITS*4-2:0], shreg_q[IN_WIDTH-1]};
            shreg_q <= {shreg_q[IN_WIDTH-2:0], 1'b0};
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/display_scan_controller.sv
// Converts a signed sample to sign/hundreds/tens/units and time-multiplexes
// the four digits onto a shared registered segment bus.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned DW_IN         = 8,
    parameter int unsigned SEGMENT_WIDTH = 7,
    parameter int unsigned SCAN_DIV      = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW_IN-1:0]         number,
    output logic                     busy,
    output logic [3:0]               digit_en,
    output logic [SEGMENT_WIDTH-1:0] segments
);

    localparam int unsigned MagW = DW_IN + 1;
    localparam int unsigned CntW = $clog2(MagW + 1);
    localparam int unsigned PreW = $clog2(SCAN_DIV);

    state_e state_q, state_d;
    logic [DW_IN-1:0] number_q;
    logic             conv_sign_q;
    logic [CntW-1:0]  bit_cnt_q;
    logic [MagW-1:0]  ext, mag;
    logic [11:0]      bcd;

    logic             disp_sign_q, disp_sign_d;
    logic [3:0]       disp_h_q, disp_h_d, disp_t_q, disp_t_d, disp_u_q, disp_u_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [3:0]       digit_en_q, digit_en_d;
    logic [6:0]       seg7_d;
    logic [SEGMENT_WIDTH-1:0] segments_q;
    digit_e           dig_idx;

    assign ext = {number_q[DW_IN-1], number_q};
    assign mag = ext[MagW-1] ? (~ext + 1'b1) : ext;

    bin_to_bcd_serial #(
        .IN_WIDTH (MagW),
        .DIGITS   (3)
    ) u_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state_q == StLoad),
        .shift_en (state_q == StConvert),
        .value    (mag),
        .bcd      (bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (in_valid) state_d = StLoad;
            StLoad:    state_d = StConvert;
            StConvert: if (bit_cnt_q == CntW'(DW_IN)) state_d = StUpdate;
            StUpdate:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign in_ready = rst_n && (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_comb begin
        disp_sign_d = disp_sign_q;
        disp_h_d    = disp_h_q;
        disp_t_d    = disp_t_q;
        disp_u_d    = disp_u_q;
        if (state_q == StUpdate) begin
            disp_sign_d = conv_sign_q;
            disp_h_d    = bcd[11:8];
            disp_t_d    = bcd[7:4];
            disp_u_d    = bcd[3:0];
        end
    end

    // Scanning runs off the free prescaler only; the FSM never touches it.
    always_comb begin
        pre_d      = pre_q + 1'b1;
        digit_en_d = digit_en_q;
        if (pre_q == PreW'(SCAN_DIV - 1)) begin
            pre_d      = '0;
            digit_en_d = {digit_en_q[2:0], digit_en_q[3]};
        end
    end

    // Pattern is built from next-state values so the registered bus lines up with digit_en.
    always_comb begin
        case (digit_en_d)
            4'b0010: dig_idx = DigTens;
            4'b0100: dig_idx = DigHundreds;
            4'b1000: dig_idx = DigSign;
            default: dig_idx = DigUnits;
        endcase
        seg7_d = SegBlank;
        case (dig_idx)
            DigUnits:    seg7_d = bcd_to_seg(disp_u_d);
            DigTens:     seg7_d = (disp_h_d == 4'd0 && disp_t_d == 4'd0) ? SegBlank
                                                                         : bcd_to_seg(disp_t_d);
            DigHundreds: seg7_d = (disp_h_d == 4'd0) ? SegBlank : bcd_to_seg(disp_h_d);
            DigSign:     seg7_d = disp_sign_d ? SegMinus : SegBlank;
            default:     seg7_d = SegBlank;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            number_q    <= '0;
            conv_sign_q <= 1'b0;
            bit_cnt_q   <= '0;
            disp_sign_q <= 1'b0;
            disp_h_q    <= '0;
            disp_t_q    <= '0;
            disp_u_q    <= '0;
            pre_q       <= '0;
            digit_en_q  <= 4'b0001;
            segments_q  <= SEGMENT_WIDTH'(Seg0);
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && in_valid) begin
                number_q <= number;
            end
            if (state_q == StLoad) begin
                conv_sign_q <= number_q[DW_IN-1];
                bit_cnt_q   <= '0;
            end else if (state_q == StConvert) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            disp_sign_q <= disp_sign_d;
            disp_h_q    <= disp_h_d;
            disp_t_q    <= disp_t_d;
            disp_u_q    <= disp_u_d;
            pre_q       <= pre_d;
            digit_en_q  <= digit_en_d;
            segments_q  <= SEGMENT_WIDTH'(seg7_d);
        end
    end

    assign digit_en = digit_en_q;
    assign segments = segments_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a short scan period so that
// every digit position can be observed within a few cycles.
module tb_display_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] number;
    logic       busy;
    logic [3:0] digit_en;
    logic [6:0] segments;

    int total = 0;
    int bad   = 0;

    display_scan_controller #(
        .DW_IN         (8),
        .SEGMENT_WIDTH (7),
        .SCAN_DIV      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .number   (number),
        .busy     (busy),
        .digit_en (digit_en),
        .segments (segments)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_digit(input string tag, input logic [3:0] en, input logic [6:0] exp);
        int n = 0;
        while (digit_en !== en && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_en"}, {28'd0, digit_en}, {28'd0, en});
        chk(tag, {25'd0, segments}, {25'd0, exp});
    endtask

    // One-cycle handshake; returns just after the capturing edge.
    task automatic send(input logic [7:0] val);
        @(negedge clk);
        number   = val;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_value(input string tag, input logic [6:0] u, input logic [6:0] t,
                               input logic [6:0] h, input logic [6:0] s);
        check_digit({tag, "_u"}, 4'b0001, u);
        check_digit({tag, "_t"}, 4'b0010, t);
        check_digit({tag, "_h"}, 4'b0100, h);
        check_digit({tag, "_s"}, 4'b1000, s);
    endtask

    initial begin
        logic [6:0] exp_seg;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        number   = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {28'd0, digit_en}, 32'h1);
        chk("rst_seg", {25'd0, segments}, 32'h3F);

        // Scan cadence: 4 cycles per digit, handshake at k=6 must not disturb it
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) begin
                number   = 8'h00;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            chk($sformatf("scan_k%0d", k), {28'd0, digit_en}, 32'd1 << ((k / 4) % 4));
        end
        wait_idle("zero");
        check_value("zero", 7'h3F, 7'h00, 7'h00, 7'h00);

        // 127: latency and display hold during conversion
        wait_idle("p127_pre");
        send(8'h7F);
        chk("p127_busy", {31'd0, busy}, 32'd1);
        chk("p127_ready0", {31'd0, in_ready}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("p127_rdy_k%0d", k), {31'd0, in_ready}, 32'd0);
            exp_seg = (digit_en == 4'b0001) ? 7'h3F : 7'h00;
            chk($sformatf("p127_hold_k%0d", k), {25'd0, segments}, {25'd0, exp_seg});
        end
        tick();
        chk("p127_ready11", {31'd0, in_ready}, 32'd1);
        chk("p127_busy11", {31'd0, busy}, 32'd0);
        check_value("p127", 7'h07, 7'h5B, 7'h06, 7'h00);

        // -128
        wait_idle("m128_pre");
        send(8'h80);
        wait_idle("m128");
        check_value("m128", 7'h7F, 7'h5B, 7'h06, 7'h40);

        // -1
        send(8'hFF);
        wait_idle("m1");
        check_value("m1", 7'h06, 7'h00, 7'h00, 7'h40);

        // 0
        send(8'h00);
        wait_idle("z2");
        check_value("z2", 7'h3F, 7'h00, 7'h00, 7'h00);

        // in_valid held high through busy: only 5 captured, then 42 when ready returns
        wait_idle("hold_pre");
        @(negedge clk);
        number   = 8'h05;
        in_valid = 1'b1;
        tick();
        chk("hold_busy0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            number = 8'(20 + k);
            tick();
            chk($sformatf("hold_rdy_k%0d", k), {31'd0, in_ready}, 32'd0);
        end
        number = 8'd42;
        tick();
        chk("hold_ready11", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("hold_busy12", {31'd0, busy}, 32'd1);
        wait_idle("hold");
        check_value("d42", 7'h5B, 7'h66, 7'h00, 7'h00);

        // -5 then reset mid-conversion
        send(8'hFB);
        wait_idle("m5");
        check_value("m5", 7'h6D, 7'h00, 7'h00, 7'h40);
        send(8'h10);
        repeat (4) tick();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready_rst", {31'd0, in_ready}, 32'd0);
        chk("abort_en", {28'd0, digit_en}, 32'h1);
        chk("abort_seg", {25'd0, segments}, 32'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        repeat (20) tick();
        check_value("abort", 7'h3F, 7'h00, 7'h00, 7'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
